// File: rtl/display_mode_sequencer.sv
// display_mode_sequencer
// Selects the active pixel-path mode (1 RGB, 2 gray, 3 histogram, 4 threshold).
// Mode changes come from a debounced pushbutton (advance to the next mode) or
// from a direct request. Every change inserts exactly one blanked frame
// (oSelect = 0) and lands on a frame boundary.
// Build option: define MODE_AUTO_CYCLE_EN to also advance automatically after
// AUTO_FRAMES frames spent in one mode.
module display_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_FRAMES     = 120
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iKey_n,
  input  logic       iDirect_valid,
  input  logic [2:0] iDirect_mode,
  input  logic       iFrame_start,
  output logic [2:0] oSelect,
  output logic       oSwitch_pulse,
  output logic       oPending
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WAIT_FRAME = 2'd1,
    BLANK      = 2'd2
  } state_t;

  // Advance order 1->2->3->4->1; anything else falls back to mode 1.
  function automatic logic [2:0] next_mode(input logic [2:0] m);
    logic [2:0] n;
    case (m)
      3'd1:    n = 3'd2;
      3'd2:    n = 3'd3;
      3'd3:    n = 3'd4;
      3'd4:    n = 3'd1;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  // Key path
  logic            key_s1_q;
  logic            key_s2_q;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            db_level_q;
  logic            db_level_d;
  logic            key_evt_q;
  logic            key_evt_d;

  // Mode FSM
  state_t          state_q;
  state_t          state_d;
  logic [2:0]      select_q;
  logic [2:0]      select_d;
  logic [2:0]      target_q;
  logic [2:0]      target_d;
  logic            switch_q;
  logic            switch_d;
  logic            pending_q;
  logic            pending_d;

  logic            dir_ok_s;
  logic            evt_s;
  logic            auto_evt_s;
  logic            manual_acc_s;
  logic [2:0]      tgt_upd_s;

  // Two-flop synchroniser for the asynchronous pushbutton.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
    end else begin
      key_s1_q <= iKey_n;
      key_s2_q <= key_s1_q;
    end
  end

  // Debounce: count samples differing from the accepted level; a sample equal
  // to the accepted level (i.e. any bounce back) clears the count.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    key_evt_d  = 1'b0;
    if (key_s2_q == db_level_q) begin
      db_cnt_d = {DB_W{1'b0}};
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d   = {DB_W{1'b0}};
      db_level_d = key_s2_q;
      key_evt_d  = ~key_s2_q;  // only the press (1->0) is an event
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounce state and the one-cycle key event.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      db_cnt_q   <= {DB_W{1'b0}};
      db_level_q <= 1'b1;
      key_evt_q  <= 1'b0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      key_evt_q  <= key_evt_d;
    end
  end

`ifdef MODE_AUTO_CYCLE_EN
  localparam int FR_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(AUTO_FRAMES - 1);

  logic [FR_W-1:0] frame_cnt_q;
  logic [FR_W-1:0] frame_cnt_d;

  // Automatic advance on the AUTO_FRAMES-th frame start spent in RUN.
  always_comb begin
    if ((state_q == RUN) && iFrame_start && (frame_cnt_q == FR_LAST)) begin
      auto_evt_s = 1'b1;
    end else begin
      auto_evt_s = 1'b0;
    end
  end

  // Frame counter: counts only in RUN, restarts on manual requests.
  always_comb begin
    if (state_q != RUN) begin
      frame_cnt_d = {FR_W{1'b0}};
    end else if (manual_acc_s) begin
      frame_cnt_d = {FR_W{1'b0}};
    end else if (iFrame_start) begin
      if (frame_cnt_q == FR_LAST) begin
        frame_cnt_d = {FR_W{1'b0}};
      end else begin
        frame_cnt_d = frame_cnt_q + FR_W'(1);
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      frame_cnt_q <= {FR_W{1'b0}};
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  // Manual-only build: AUTO_FRAMES is kept so both builds share one interface.
  if (AUTO_FRAMES < 1) begin : g_auto_frames_unused
  end

  // No automatic advance in this build.
  always_comb begin
    auto_evt_s = 1'b0;
  end
`endif

  // Request decode and the target as updated by this cycle's requests;
  // a valid direct request takes precedence over a key/auto event.
  always_comb begin
    dir_ok_s = iDirect_valid && (iDirect_mode >= 3'd1) && (iDirect_mode <= 3'd4);
    evt_s    = key_evt_q | auto_evt_s;
    if (dir_ok_s) begin
      tgt_upd_s = iDirect_mode;
    end else if (evt_s) begin
      tgt_upd_s = next_mode(target_q);
    end else begin
      tgt_upd_s = target_q;
    end
  end

  // Next-state logic of the mode FSM.
  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    target_d     = target_q;
    switch_d     = 1'b0;
    manual_acc_s = 1'b0;
    case (state_q)
      RUN: begin
        if (dir_ok_s && (iDirect_mode != select_q)) begin
          target_d     = iDirect_mode;
          state_d      = WAIT_FRAME;
          manual_acc_s = 1'b1;
        end else if (evt_s) begin
          target_d     = next_mode(select_q);
          state_d      = WAIT_FRAME;
          manual_acc_s = key_evt_q;
        end else begin
          state_d = RUN;
        end
      end
      WAIT_FRAME: begin
        target_d = tgt_upd_s;
        if (iFrame_start) begin
          select_d = 3'd0;
          state_d  = BLANK;
        end else begin
          state_d = WAIT_FRAME;
        end
      end
      BLANK: begin
        target_d = tgt_upd_s;
        if (iFrame_start) begin
          select_d = tgt_upd_s;
          switch_d = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = BLANK;
        end
      end
      default: begin
        state_d  = RUN;
        select_d = 3'd1;
        target_d = 3'd1;
      end
    endcase
    pending_d = (state_d != RUN);
  end

  // Mode FSM state and registered outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= RUN;
      select_q  <= 3'd1;
      target_q  <= 3'd1;
      switch_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      select_q  <= select_d;
      target_q  <= target_d;
      switch_q  <= switch_d;
      pending_q <= pending_d;
    end
  end

  assign oSelect       = select_q;
  assign oSwitch_pulse = switch_q;
  assign oPending      = pending_q;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Directed bench for display_mode_sequencer (DEBOUNCE_CYCLES=4, AUTO_FRAMES=3).
// Honours MODE_AUTO_CYCLE_EN to pick the expected auto-advance behaviour.
module tb_display_mode_sequencer;

  localparam int DB = 4;
  localparam int AF = 3;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iKey_n;
  logic       iDirect_valid;
  logic [2:0] iDirect_mode;
  logic       iFrame_start;
  logic [2:0] oSelect;
  logic       oSwitch_pulse;
  logic       oPending;

  int checks   = 0;
  int errors   = 0;
  int sw_cnt   = 0;
  int seen2    = 0;
  int sw_base  = 0;
  int s2_base  = 0;

  display_mode_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .AUTO_FRAMES    (AF)
  ) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iKey_n       (iKey_n),
    .iDirect_valid(iDirect_valid),
    .iDirect_mode (iDirect_mode),
    .iFrame_start (iFrame_start),
    .oSelect      (oSelect),
    .oSwitch_pulse(oSwitch_pulse),
    .oPending     (oPending)
  );

  always #5 iClk = ~iClk;

  // Cumulative monitors sampled mid-cycle.
  always @(negedge iClk) begin
    if (oSwitch_pulse) sw_cnt++;
    if (oSelect == 3'd2) seen2++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    tick(2);
    iRst = 1'b0;
    tick(1);
    sw_base = sw_cnt;
    s2_base = seen2;
  endtask

  task automatic press(input int n);
    iKey_n = 1'b0;
    tick(n);
    iKey_n = 1'b1;
    tick(10);
  endtask

  task automatic frame(input logic dv, input logic [2:0] dm);
    iFrame_start  = 1'b1;
    iDirect_valid = dv;
    iDirect_mode  = dm;
    tick(1);
    iFrame_start  = 1'b0;
    iDirect_valid = 1'b0;
    tick(2);
  endtask

  task automatic direct(input logic [2:0] dm);
    iDirect_valid = 1'b1;
    iDirect_mode  = dm;
    tick(1);
    iDirect_valid = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  initial begin
    iRst = 1'b1; iKey_n = 1'b1; iDirect_valid = 1'b0;
    iDirect_mode = 3'd0; iFrame_start = 1'b0;

    // Reset state
    do_reset();
    check("rst_select", oSelect, 1);
    check("rst_pending", oPending, 0);
    check("rst_pulse", oSwitch_pulse, 0);

    // Glitch of 3 cycles: no event
    press(3);
    check("glitch_select", oSelect, 1);
    check("glitch_pending", oPending, 0);

    // Single press, then two frames: 1 -> 0 -> 2
    do_reset();
    press(6);
    check("press_pending", oPending, 1);
    check("press_select_hold", oSelect, 1);
    frame(1'b0, 3'd0);
    check("press_blank", oSelect, 0);
    check("press_blank_pending", oPending, 1);
    iFrame_start = 1'b1;
    tick(1);
    iFrame_start = 1'b0;
    check("press_switch_select", oSelect, 2);
    check("press_switch_pulse", oSwitch_pulse, 1);
    tick(1);
    check("press_pulse_width", oSwitch_pulse, 0);
    check("press_done_pending", oPending, 0);
    check("press_pulse_count", sw_cnt - sw_base, 1);

    // Two presses before the first frame: 1 -> 3 with no 2 shown
    do_reset();
    press(6);
    press(6);
    frame(1'b0, 3'd0);
    frame(1'b0, 3'd0);
    check("two_press_select", oSelect, 3);
    check("two_press_no_2", seen2 - s2_base, 0);
    check("two_press_pulses", sw_cnt - sw_base, 1);

    // Direct mode 4 in the same cycle as a key event: direct wins
    do_reset();
    iKey_n = 1'b0;
    tick(6);
    iDirect_valid = 1'b1;
    iDirect_mode  = 3'd4;
    tick(1);
    iDirect_valid = 1'b0;
    iKey_n = 1'b1;
    tick(10);
    check("collide_pending", oPending, 1);
    frame(1'b0, 3'd0);
    frame(1'b0, 3'd0);
    check("collide_select", oSelect, 4);

    // Out-of-range and same-mode direct requests are ignored
    direct(3'd6);
    check("dir6_pending", oPending, 0);
    direct(3'd0);
    check("dir0_pending", oPending, 0);
    direct(3'd4);
    check("dir_same_pending", oPending, 0);
    frame(1'b0, 3'd0);
    frame(1'b0, 3'd0);
    check("dir_ignored_select", oSelect, 4);

    // Plain direct request 4 -> 3
    direct(3'd3);
    check("dir3_pending", oPending, 1);
    frame(1'b0, 3'd0);
    frame(1'b0, 3'd0);
    check("dir3_select", oSelect, 3);

    // Request in the same cycle as the switching frame start is used
    direct(3'd2);
    frame(1'b0, 3'd0);
    check("late_blank", oSelect, 0);
    frame(1'b1, 3'd1);
    check("late_req_select", oSelect, 1);
    check("late_req_pending", oPending, 0);

    // Reset while in BLANK
    do_reset();
    direct(3'd2);
    frame(1'b0, 3'd0);
    check("midrst_blank", oSelect, 0);
    iRst = 1'b1;
    #1;
    check("midrst_select_async", oSelect, 1);
    check("midrst_pending_async", oPending, 0);
    tick(1);
    iRst = 1'b0;
    tick(1);
    frame(1'b0, 3'd0);
    frame(1'b0, 3'd0);
    check("midrst_select_after", oSelect, 1);
    check("midrst_no_pulse", sw_cnt - sw_base, 0);

    // Idle frames in mode 1
    do_reset();
    frame(1'b0, 3'd0);
    frame(1'b0, 3'd0);
    frame(1'b0, 3'd0);
`ifdef MODE_AUTO_CYCLE_EN
    check("auto_pending", oPending, 1);
    check("auto_hold", oSelect, 1);
    frame(1'b0, 3'd0);
    check("auto_blank", oSelect, 0);
    frame(1'b0, 3'd0);
    check("auto_select", oSelect, 2);
    check("auto_pulses", sw_cnt - sw_base, 1);
`else
    check("idle_pending", oPending, 0);
    frame(1'b0, 3'd0);
    frame(1'b0, 3'd0);
    check("idle_select", oSelect, 1);
    check("idle_pulses", sw_cnt - sw_base, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_mode_sequencer.md
DISPLAY_MODE_SEQUENCER -- requirements
Module: display_mode_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: number of consecutive stable synchronised key samples needed to accept a new key level.
REQ-002 Parameter AUTO_FRAMES, default 120: frames spent in each mode before an automatic advance (auto-cycle build only).
REQ-003 Clock and reset are decided: one clock; reset is asynchronous and active-high.
REQ-004 iClk  input  1  system clock; all logic is on its rising edge.
REQ-005 iRst  input  1  asynchronous, active-high reset.
REQ-006 iKey_n  input  1  raw pushbutton, active-low, asynchronous to iClk; a press requests the next mode.
REQ-007 iDirect_valid  input  1  single-cycle strobe for a direct mode request.
REQ-008 iDirect_mode  input  3  requested mode, sampled while iDirect_valid=1.
REQ-009 iFrame_start  input  1  single-cycle pulse marking the first pixel of each frame.
REQ-010 oSelect  output  3  mode code to the pixel-path arbiter (1 RGB, 2 gray, 3 histogram, 4 threshold, 0 blank).
REQ-011 oSwitch_pulse  output  1  one-cycle strobe when oSelect takes a new non-zero mode.
REQ-012 oPending  output  1  a mode change is queued or in progress.

Function
REQ-013 iKey_n shall pass through a 2-flop synchroniser before any other use.
REQ-014 Debounce: any change of the synchronised level shall clear the counter; the debounced level shall update after DEBOUNCE_CYCLES consecutive equal samples.
REQ-015 A debounced 1->0 transition shall produce exactly one key event; release shall produce none.
REQ-016 Advance order shall be 1->2->3->4->1.
REQ-017 A direct request with iDirect_mode outside 1..4 shall be ignored.
REQ-018 FSM states shall be RUN, WAIT_FRAME and BLANK.
REQ-019 RUN, key event: target = next(oSelect); state -> WAIT_FRAME.
REQ-020 RUN, valid direct request: if iDirect_mode != oSelect, target = iDirect_mode and state -> WAIT_FRAME; otherwise the request is ignored.
REQ-021 WAIT_FRAME and BLANK: a key event sets target = next(target); a valid direct request overwrites target.
REQ-022 If a key event and a valid direct request occur in the same cycle, the direct request shall win.
REQ-023 WAIT_FRAME, iFrame_start: oSelect <= 0; state -> BLANK (exactly one blanked frame).
REQ-024 BLANK, iFrame_start: oSelect <= target; oSwitch_pulse = 1 for one cycle; state -> RUN.
REQ-025 A request arriving in the same cycle as iFrame_start shall update target before the transition uses it.
REQ-026 oSelect and oSwitch_pulse are registered: one cycle of latency after the iFrame_start cycle.
REQ-027 oPending shall be 1 in WAIT_FRAME and BLANK, and 0 in RUN.
REQ-028 oSelect shall never change except on a cycle following iFrame_start, or on reset.

Reset
REQ-029 Reset values: oSelect=1, target=1, state RUN, oPending=0, oSwitch_pulse=0, debounce counter 0, debounced level 1, synchroniser flops 1, frame counter 0.
REQ-030 Reset asserted mid-sequence (WAIT_FRAME or BLANK) shall discard the queued target and apply all reset values at once.

Configuration
REQ-031 Macro MODE_AUTO_CYCLE_EN defined: the block shall count iFrame_start pulses in RUN and, on the AUTO_FRAMES-th pulse, raise an internal event identical to a key event.
REQ-032 The frame counter shall clear on any accepted manual request and on leaving RUN.
REQ-033 Macro MODE_AUTO_CYCLE_EN undefined: no frame counter shall exist, and modes shall change only on manual requests.

Verification (DEBOUNCE_CYCLES=4, AUTO_FRAMES=3)
REQ-034 Reset, then hold iKey_n low 6 cycles, then 2 frames -> oSelect 1 -> 0 -> 2; one oSwitch_pulse; oPending high between the press and the switch.
REQ-035 Glitch iKey_n low for 3 cycles -> no event; oSelect stays 1; oPending stays 0.
REQ-036 Two debounced presses before the first iFrame_start -> after 2 frames oSelect=3; no intermediate 2.
REQ-037 iDirect_valid with mode 4 in the same cycle as a key event -> final oSelect=4; iDirect_mode=6 -> ignored.
REQ-038 iRst pulsed while in BLANK -> oSelect=1 at once; oPending=0; no oSwitch_pulse.
REQ-039 MODE_AUTO_CYCLE_EN build, 3 frames idle in mode 1 -> blank frame, then oSelect=2; undefined build -> oSelect stays 1.
